// File: rtl/timer_dev_if.sv
// Bridge-side bus of one timer window: word offset, write strobe, data, IRQ,
// plus a read-only view of the FSM state for observation.
interface timer_dev_if;
  logic [3:2]  Addr;
  logic        WE;
  logic [31:0] DIn;
  logic [31:0] DOut;
  logic        IRQ;
  logic [1:0]  dbg_state;

  // Handshake: single-cycle strobe. WE high at a rising clock edge is a write
  // of DIn to Addr at that edge. There is no ready; writes always complete.
  // DOut is a combinational read of Addr with no strobe.
  modport master (output Addr, WE, DIn, input DOut, IRQ, dbg_state);
  modport slave  (input Addr, WE, DIn, output DOut, IRQ, dbg_state);
endinterface

// File: rtl/timer_dev.sv
// Programmable countdown timer on the system bridge. It supports one-shot and
// auto-reload modes and a maskable level IRQ.
module timer_dev (
  input  logic        Clk,
  input  logic        Reset,
  timer_dev_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;

  logic enable;
  logic auto_reload;
  assign enable      = ctrl_q[0];
  assign auto_reload = (ctrl_q[2:1] == 2'b01);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      ctrl_q   <= 4'd0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;

    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_LOAD;
      end
      S_LOAD: begin
        count_d = preset_q;
        flag_d  = 1'b0;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (count_q <= 32'd1) begin
          count_d = 32'd0;
          state_d = S_INT;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      S_INT: begin
        flag_d = 1'b1;
        if (auto_reload) begin
          state_d = S_LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // CPU writes are applied last so they win over the FSM's own updates.
    if (bus.WE) begin
      case (bus.Addr)
        2'd0: begin
          ctrl_d = bus.DIn[3:0];
          flag_d = 1'b0;
        end
        2'd1: begin
          preset_d = bus.DIn;
          flag_d   = 1'b0;
          state_d  = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (bus.Addr)
      2'd0:    bus.DOut = {28'd0, ctrl_q};
      2'd1:    bus.DOut = preset_q;
      2'd2:    bus.DOut = count_q;
      default: bus.DOut = 32'd0;
    endcase
  end

  assign bus.IRQ       = ctrl_q[3] & flag_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev. It combines a register-access vector
// table, directed corner sequences, and randomized count runs checked
// against a closed-form timeline model.
module tb_timer_dev;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  timer_dev_if bus ();

  timer_dev dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.WE   = 1'b0;
    bus.Addr = 2'd0;
    bus.DIn  = 32'd0;
    rst_n    = 1'b0;
    #2;
    rst_n    = 1'b1;
    step(1);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.Addr = a;
    bus.DIn  = d;
    bus.WE   = 1'b1;
    @(posedge clk);
    #1;
    bus.WE   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.Addr = a;
    #1;
    d = bus.DOut;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Closed-form timeline: n = edges after the CTRL write that enabled the timer.
  // The count starts at edge 2. An auto-reload run repeats every eff+2 edges.
  function automatic void model(input int p, input logic [3:0] c, input int n,
                                output logic [31:0] cnt, output logic irq);
    int eff;
    int j;
    int m;
    eff = (p < 1) ? 1 : p;
    cnt = 32'd0;
    irq = 1'b0;
    if (n >= 2) begin
      j = n - 2;
      if (c[2:1] == 2'b01) begin
        m   = j % (eff + 2);
        cnt = (m <= p) ? 32'(p - m) : 32'd0;
        irq = c[3] && (m == eff + 1);
      end else begin
        cnt = (j <= p) ? 32'(p - j) : 32'd0;
        irq = c[3] && (n >= 3 + eff);
      end
    end
  endfunction

  task automatic run_trial(input int p, input logic [3:0] c, input int ncyc);
    logic [31:0] ecnt;
    logic        eirq;
    logic [31:0] d;
    int          eff;
    eff = (p < 1) ? 1 : p;
    do_reset();
    wr(2'd1, 32'(p));
    wr(2'd0, {28'd0, c});
    bus.Addr = 2'd2;
    for (int k = 1; k <= ncyc; k++) begin
      step(1);
      model(p, c, k, ecnt, eirq);
      if (k >= 2) check($sformatf("count p=%0d c=%h n=%0d", p, c, k), bus.DOut, ecnt);
      check($sformatf("irq p=%0d c=%h n=%0d", p, c, k), {31'd0, bus.IRQ}, {31'd0, eirq});
    end
    rd(2'd0, d);
    if (c[2:1] != 2'b01 && ncyc >= 3 + eff)
      check("ctrl after one-shot", d, {28'd0, c[3:1], 1'b0});
    else
      check("ctrl while running", d, {28'd0, c});
  endtask

  typedef struct {
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [31:0] d;
    logic [3:0]  c;
    int          p;
    int          eff;

    tests = 0;
    fails = 0;
    bus.WE   = 1'b0;
    bus.Addr = 2'd0;
    bus.DIn  = 32'd0;
    rst_n    = 1'b0;

    vecs[0] = '{2'd0, 1'b1, 32'hFFFF_FFFE, 32'h0000_000E};
    vecs[1] = '{2'd1, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[2] = '{2'd2, 1'b1, 32'h0000_1234, 32'h0000_0000};
    vecs[3] = '{2'd3, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[4] = '{2'd0, 1'b0, 32'h0000_0000, 32'h0000_000E};
    vecs[5] = '{2'd1, 1'b1, 32'h0000_0000, 32'h0000_0000};
    vecs[6] = '{2'd0, 1'b1, 32'h0000_0006, 32'h0000_0006};
    vecs[7] = '{2'd0, 1'b1, 32'h0000_0000, 32'h0000_0000};

    // Reset state
    #3;
    check("reset irq", {31'd0, bus.IRQ}, 32'd0);
    for (int a = 0; a < 3; a++) begin
      rd(2'(a), d);
      check($sformatf("reset reg%0d", a), d, 32'd0);
    end
    rst_n = 1'b1;
    step(1);

    // Register access table (Enable kept clear)
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].we) wr(vecs[i].addr, vecs[i].din);
      rd(vecs[i].addr, d);
      check($sformatf("vec%0d", i), d, vecs[i].exp);
    end

    // Reset mid-count
    do_reset();
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    step(5);
    rd(2'd2, d);
    check("midcount count", d, 32'd7);
    rst_n = 1'b0;
    #1;
    check("async rst irq", {31'd0, bus.IRQ}, 32'd0);
    check("async rst state", {30'd0, bus.dbg_state}, {30'd0, ST_IDLE});
    for (int a = 0; a < 3; a++) begin
      rd(2'(a), d);
      check($sformatf("async rst reg%0d", a), d, 32'd0);
    end
    rst_n = 1'b1;
    step(1);

    // One-shot, IM set
    do_reset();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    step(2);
    rd(2'd2, d);
    check("oneshot E2", d, 32'd5);
    step(5);
    rd(2'd2, d);
    check("oneshot E7", d, 32'd0);
    check("oneshot irq E7", {31'd0, bus.IRQ}, 32'd0);
    step(1);
    check("oneshot irq E8", {31'd0, bus.IRQ}, 32'd1);
    step(3);
    check("oneshot irq hold", {31'd0, bus.IRQ}, 32'd1);
    rd(2'd0, d);
    check("oneshot ctrl", d, 32'h8);
    wr(2'd0, 32'h8);
    check("oneshot irq cleared", {31'd0, bus.IRQ}, 32'd0);

    // Auto-reload, four periods
    run_trial(3, 4'hB, 22);

    // Masked one-shot, then CTRL write clears the hidden flag
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    step(5);
    rd(2'd2, d);
    check("mask count", d, 32'd0);
    check("mask irq", {31'd0, bus.IRQ}, 32'd0);
    rd(2'd0, d);
    check("mask ctrl", d, 32'd0);
    wr(2'd0, 32'h8);
    check("mask unmask irq", {31'd0, bus.IRQ}, 32'd0);
    step(2);
    check("mask unmask irq later", {31'd0, bus.IRQ}, 32'd0);

    // Writes to COUNT and the unused offset while counting
    do_reset();
    wr(2'd1, 32'd6);
    wr(2'd0, 32'h1);
    step(2);
    rd(2'd2, d);
    check("ro count E2", d, 32'd6);
    wr(2'd2, 32'h1234);
    rd(2'd2, d);
    check("ro count E3", d, 32'd5);
    wr(2'd3, 32'h1234);
    rd(2'd2, d);
    check("ro count E4", d, 32'd4);
    rd(2'd3, d);
    check("unused reads 0", d, 32'd0);
    step(1);
    rd(2'd2, d);
    check("ro count E5", d, 32'd3);
    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd0, d);
    check("ctrl upper bits", d, 32'hF);

    // CTRL write landing in the INT cycle
    do_reset();
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    step(3);
    check("simul state INT", {30'd0, bus.dbg_state}, {30'd0, ST_INT});
    wr(2'd0, 32'h9);
    rd(2'd0, d);
    check("simul ctrl", d, 32'h9);
    check("simul irq", {31'd0, bus.IRQ}, 32'd0);
    check("simul state IDLE", {30'd0, bus.dbg_state}, {30'd0, ST_IDLE});
    step(1);
    check("simul state LOAD", {30'd0, bus.dbg_state}, {30'd0, ST_LOAD});
    step(1);
    rd(2'd2, d);
    check("simul reload", d, 32'd1);
    check("simul state CNT", {30'd0, bus.dbg_state}, {30'd0, ST_CNT});

    // Randomized runs against the timeline model
    for (int t = 0; t < 24; t++) begin
      p   = $urandom_range(0, 9);
      c   = {3'($urandom_range(0, 7)), 1'b1};
      eff = (p < 1) ? 1 : p;
      run_trial(p, c, $urandom_range(2, 3 * (eff + 2) + 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
